sopc_pio_key: RTL and testbench



---
 rtl/sopc_pio_key_if.sv | 29 ++
 rtl/sopc_pio_key.sv | 106 ++++++++++
 tb/tb_sopc_pio_key.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sopc_pio_key_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// The level interrupt travels with the bus so the interrupt controller
// side sees one connection per peripheral.
interface sopc_pio_key_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );
endinterface

// File: rtl/sopc_pio_key.sv
// Input PIO for buttons/switches: 2-flop synchronizer, live data read,
// sticky write-one-to-clear edge capture and a maskable level interrupt.
//
// Register map (word address):
//   0 | synchronized input data (read only)
//   1 | reserved, reads 0
//   2 | irq mask (read/write)
//   3 | edge capture (read, write-one-to-clear)
module sopc_pio_key #(
    parameter int                    DATA_WIDTH       = 4,
    parameter int                    EDGE_TYPE        = 1,
    parameter logic [DATA_WIDTH-1:0] SYNC_RESET_VALUE = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    sopc_pio_key_if.slave         bus
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [DATA_WIDTH-1:0] sync1_q, sync1_d;
    logic [DATA_WIDTH-1:0] sync2_q, sync2_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [31:0]           readdata_q, readdata_d;

    logic [DATA_WIDTH-1:0] edge_det;
    logic                  wr_en;

    // Only the low DATA_WIDTH bits of writedata are architecturally used.
    logic [31:0] unused_writedata;
    assign unused_writedata = bus.writedata;

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Pipeline the raw inputs: two stages for metastability, one for edge history.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Select the configured edge flavour from the synchronized data and its history.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = sync2_q & ~prev_q;
            1:       edge_det = ~sync2_q & prev_q;
            2:       edge_det = sync2_q ^ prev_q;
            default: edge_det = sync2_q & ~prev_q;
        endcase
    end

    // Register writes: mask load and write-one-to-clear capture, with new edges winning over clears.
    always_comb begin
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;
        if (wr_en && (bus.address == ADDR_MASK)) begin
            irq_mask_d = bus.writedata[DATA_WIDTH-1:0];
        end
        if (wr_en && (bus.address == ADDR_EDGE)) begin
            edge_capture_d = edge_capture_q & ~bus.writedata[DATA_WIDTH-1:0];
        end
        edge_capture_d = edge_capture_d | edge_det;
    end

    // Read mux, sampled every clock so data follows the address by one cycle.
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = sync2_q;
            ADDR_RSVD: readdata_d                 = '0;
            ADDR_MASK: readdata_d[DATA_WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE: readdata_d[DATA_WIDTH-1:0] = edge_capture_q;
            default:   readdata_d                 = '0;
        endcase
    end

    // State registers; the synchronizer resets to the idle input level to avoid a false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= SYNC_RESET_VALUE;
            sync2_q        <= SYNC_RESET_VALUE;
            prev_q         <= SYNC_RESET_VALUE;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    // Interrupt is a pure function of registers, so it drops with reset without a clock.
    assign bus.irq      = |(edge_capture_q & irq_mask_q);
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_sopc_pio_key.sv
// Bench for sopc_pio_key: a falling-edge instance and an any-edge instance
// share one bus driver; each is exercised while the other is held in reset.
module tb_sopc_pio_key;

    logic        clk;
    logic        rst_f_n;
    logic        rst_a_n;
    logic [3:0]  in_f;
    logic [3:0]  in_a;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        sel_a;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    sopc_pio_key_if bus_f ();
    sopc_pio_key_if bus_a ();

    assign bus_f.address    = address;
    assign bus_f.chipselect = chipselect;
    assign bus_f.write_n    = write_n;
    assign bus_f.writedata  = writedata;
    assign bus_a.address    = address;
    assign bus_a.chipselect = chipselect;
    assign bus_a.write_n    = write_n;
    assign bus_a.writedata  = writedata;

    sopc_pio_key #(.DATA_WIDTH(4), .EDGE_TYPE(1)) dut_f (
        .clk     (clk),
        .reset_n (rst_f_n),
        .in_port (in_f),
        .bus     (bus_f.slave)
    );

    sopc_pio_key #(.DATA_WIDTH(4), .EDGE_TYPE(2)) dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .in_port (in_a),
        .bus     (bus_a.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock, landing 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cur_rd();
        return sel_a ? bus_a.readdata : bus_f.readdata;
    endfunction

    function automatic logic [31:0] cur_irq();
        return {31'd0, sel_a ? bus_a.irq : bus_f.irq};
    endfunction

    // Present a read address and queue the value the next edge must return.
    task automatic rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        address    = addr;
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        cyc();
        chk(tag_q.pop_front(), cur_rd(), exp_q.pop_front());
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = data;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sel_a        = 1'b0;
        rst_f_n      = 1'b0;
        rst_a_n      = 1'b0;
        in_f         = 4'hF;
        in_a         = 4'hE;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = '0;

        // ---------------- falling-edge instance ----------------
        repeat (3) cyc();
        chk("rst_readdata", bus_f.readdata, 32'h0);
        chk("rst_irq", cur_irq(), 32'h0);
        rst_f_n = 1'b1;
        rd("data_after_rst", 2'd0, 32'h0000_000F);
        for (int i = 0; i < 10; i++) begin
            rd("no_spurious_edge", 2'd3, 32'h0);
            chk("no_spurious_irq", cur_irq(), 32'h0);
        end

        // bit 1 falls: captured on the third edge after the change
        in_f = 4'hD;
        cyc();
        cyc();
        rd("edge_not_yet", 2'd3, 32'h0);
        rd("edge_captured", 2'd3, 32'h2);
        chk("irq_masked_off", cur_irq(), 32'h0);
        rd("data_after_fall", 2'd0, 32'h0000_000D);

        wr(2'd2, 32'h2);
        chk("irq_on_mask", cur_irq(), 32'h1);
        rd("mask_readback", 2'd2, 32'h2);

        wr(2'd3, 32'h1);
        rd("w1c_other_bit", 2'd3, 32'h2);
        chk("irq_kept", cur_irq(), 32'h1);

        wr(2'd3, 32'h2);
        chk("irq_cleared", cur_irq(), 32'h0);
        rd("edge_cleared", 2'd3, 32'h0);

        // rising edge is not captured for the falling-edge instance
        in_f = 4'hF;
        repeat (3) cyc();
        rd("rise_ignored", 2'd3, 32'h0);

        // new falling edge lands on the same edge as a clearing write
        in_f = 4'hD;
        cyc();
        cyc();
        wr(2'd3, 32'h2);
        chk("set_wins_irq", cur_irq(), 32'h1);
        rd("set_wins_edge", 2'd3, 32'h2);

        wr(2'd2, 32'h0);
        chk("irq_off_by_mask", cur_irq(), 32'h0);

        rd("reserved_zero", 2'd1, 32'h0);
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        rd("wr0_edge_kept", 2'd3, 32'h2);
        rd("wr0_mask_kept", 2'd2, 32'h0);
        rd("wr0_data_kept", 2'd0, 32'h0000_000D);

        wr(2'd2, 32'hFFFF_FFFF);
        rd("mask_width", 2'd2, 32'h0000_000F);
        chk("irq_full_mask", cur_irq(), 32'h1);

        // write strobe without chipselect is ignored
        address    = 2'd2;
        chipselect = 1'b0;
        write_n    = 1'b0;
        writedata  = 32'h0;
        cyc();
        write_n = 1'b1;
        rd("no_cs_ignored", 2'd2, 32'h0000_000F);

        // ---------------- any-edge instance ----------------
        rst_f_n = 1'b0;
        sel_a   = 1'b1;
        rst_a_n = 1'b1;
        repeat (4) cyc();
        // input held at 0xE against a 0xF reset value gives one startup edge on bit 0
        rd("any_startup_edge", 2'd3, 32'h1);
        wr(2'd3, 32'hF);
        rd("any_cleared0", 2'd3, 32'h0);
        wr(2'd2, 32'h1);
        chk("any_irq_idle", cur_irq(), 32'h0);

        in_a = 4'hF;
        cyc();
        cyc();
        rd("any_rise_not_yet", 2'd3, 32'h0);
        rd("any_rise", 2'd3, 32'h1);
        chk("any_rise_irq", cur_irq(), 32'h1);

        wr(2'd3, 32'h1);
        chk("any_clr_irq", cur_irq(), 32'h0);
        rd("any_cleared1", 2'd3, 32'h0);

        in_a = 4'hE;
        cyc();
        cyc();
        rd("any_fall_not_yet", 2'd3, 32'h0);
        rd("any_fall", 2'd3, 32'h1);
        chk("any_fall_irq", cur_irq(), 32'h1);

        // asynchronous reset between clock edges
        #2;
        rst_a_n = 1'b0;
        #1;
        chk("async_rst_irq", cur_irq(), 32'h0);
        chk("async_rst_rd", bus_a.readdata, 32'h0);
        cyc();
        rst_a_n = 1'b1;
        rd("mask_after_rst", 2'd2, 32'h0);
        chk("irq_after_rst", cur_irq(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Backstop so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
